// File: rtl/l0_maxpool_if.sv
// Bus bundle between the layer-0 max-pool stage, its upstream conv read
// port and the downstream random-access reader.
//
// Handshake: rdy_in is a one-sided strobe from upstream. When the stage is
// idle (and the frame is not complete) a high rdy_in on a rising edge commits
// the upstream to presenting the four window samples on din_0/din_1 during the
// next four cycles, in order TL, TR, BL, BR. There is no back-pressure.
// Reads are fire-and-forget: addr_rd in cycle t gives dout_* in cycle t+1.
interface l0_maxpool_if #(
   parameter int DATA_WIDTH = 18,
   parameter int ADDR_WIDTH = 8
);
   logic                  tx_done;
   logic                  rdy_in;
   logic [DATA_WIDTH-1:0] din_0;
   logic [DATA_WIDTH-1:0] din_1;
   logic [ADDR_WIDTH-1:0] addr_rd;
   logic [DATA_WIDTH-1:0] dout_0;
   logic [DATA_WIDTH-1:0] dout_1;
   logic [ADDR_WIDTH-1:0] wr_cnt;
   logic                  done;
   logic [2:0]            fsm_state;

   // Pool stage side.
   modport slave (
      input  tx_done, rdy_in, din_0, din_1, addr_rd,
      output dout_0, dout_1, wr_cnt, done, fsm_state
   );

   // Upstream / reader / bench side.
   modport master (
      output tx_done, rdy_in, din_0, din_1, addr_rd,
      input  dout_0, dout_1, wr_cnt, done, fsm_state
   );
endinterface

// File: rtl/l0_maxpool.sv
// 2x2 max-pool stage behind the first conv layer. Each 4-sample window (two
// channels in parallel) is reduced to its unsigned maximum and stored in a
// per-channel pooled RAM; a frame holds N_OUT pooled entries per channel.
// fsm_state mirrors the window sequencer for observation.
module l0_maxpool #(
   parameter int DATA_WIDTH = 18,
   parameter int N_OUT      = 169,
   parameter int ADDR_WIDTH = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   l0_maxpool_if.slave  bus
);

   localparam int                    DEPTH    = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] FULL_CNT = ADDR_WIDTH'(N_OUT);
   localparam logic [ADDR_WIDTH-1:0] CNT_ONE  = ADDR_WIDTH'(1);

   // One state per upstream cycle: idle, then the four window samples.
   typedef enum logic [2:0] {
      S_WAIT = 3'd0,
      S_C0   = 3'd1,
      S_C1   = 3'd2,
      S_C2   = 3'd3,
      S_C3   = 3'd4
   } state_t;

   state_t                state;
   logic [DATA_WIDTH-1:0] max_0;
   logic [DATA_WIDTH-1:0] max_1;
   logic [ADDR_WIDTH-1:0] wr_cnt;
   logic                  done;
   logic [DATA_WIDTH-1:0] dout_0_q;
   logic [DATA_WIDTH-1:0] dout_1_q;

   // Pooled storage; sized to the full address space so any addr_rd is a
   // legal index (entries at or above N_OUT are simply never written).
   logic [DATA_WIDTH-1:0] ram_0 [DEPTH];
   logic [DATA_WIDTH-1:0] ram_1 [DEPTH];

   logic [DATA_WIDTH-1:0] win_0;
   logic [DATA_WIDTH-1:0] win_1;
   logic                  wr_en;

   // Running max including the sample currently on din, and the write strobe
   // for the last slot of a window (suppressed by a frame restart).
   always_comb begin
      win_0 = max_0;
      win_1 = max_1;
      if (bus.din_0 > max_0) win_0 = bus.din_0;
      if (bus.din_1 > max_1) win_1 = bus.din_1;
      wr_en = rst_n && (state == S_C3) && !bus.tx_done;
   end

   // Window sequencer, running max, entry counter and sticky frame-done flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_WAIT;
         max_0  <= '0;
         max_1  <= '0;
         wr_cnt <= '0;
         done   <= 1'b0;
      end else if (bus.tx_done) begin
         // Frame restart wins over everything, including a window in C3.
         state  <= S_WAIT;
         wr_cnt <= '0;
         done   <= 1'b0;
      end else begin
         // done follows the final write by one edge.
         if (wr_cnt == FULL_CNT) done <= 1'b1;
         case (state)
            S_WAIT: begin
               // The count guard covers the single cycle between the last
               // write and done rising, so wr_cnt can never pass N_OUT.
               if (bus.rdy_in && !done && (wr_cnt != FULL_CNT)) state <= S_C0;
            end
            S_C0: begin
               max_0 <= bus.din_0;
               max_1 <= bus.din_1;
               state <= S_C1;
            end
            S_C1: begin
               max_0 <= win_0;
               max_1 <= win_1;
               state <= S_C2;
            end
            S_C2: begin
               max_0 <= win_0;
               max_1 <= win_1;
               state <= S_C3;
            end
            S_C3: begin
               wr_cnt <= wr_cnt + CNT_ONE;
               state  <= S_WAIT;
            end
            default: state <= S_WAIT;
         endcase
      end
   end

   // Write port: the pooled window lands at the current entry index.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         ram_0[wr_cnt] <= win_0;
         ram_1[wr_cnt] <= win_1;
      end
   end

   // Read port: registered, so a same-cycle write to addr_rd returns old data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout_0_q <= '0;
         dout_1_q <= '0;
      end else begin
         dout_0_q <= ram_0[bus.addr_rd];
         dout_1_q <= ram_1[bus.addr_rd];
      end
   end

   assign bus.dout_0    = dout_0_q;
   assign bus.dout_1    = dout_1_q;
   assign bus.wr_cnt    = wr_cnt;
   assign bus.done      = done;
   assign bus.fsm_state = state;

endmodule

// File: tb/tb_l0_maxpool.sv
// Bench for l0_maxpool: window driver, read driver feeding an expected-data
// queue, a negedge monitor that drains it, and direct checks of the counters.
module tb_l0_maxpool;

   localparam int DW = 18;
   localparam int AW = 8;
   localparam int NO = 169;
   localparam int W  = 2 * DW;

   typedef logic [DW-1:0] win_t [4];

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   l0_maxpool_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   l0_maxpool #(.DATA_WIDTH(DW), .N_OUT(NO), .ADDR_WIDTH(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [W-1:0]  exp_q [$];
   logic [W-1:0]  mon_exp;
   int            n_cmp = 0;
   int            n_fail = 0;
   logic [DW-1:0] mdl_0 [NO];
   logic [DW-1:0] mdl_1 [NO];
   int            mdl_cnt = 0;
   logic          rd_issue = 1'b0;
   logic          rd_vld_q = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference reduction: largest of the four window samples.
   function automatic logic [DW-1:0] max_of(input win_t w);
      logic [DW-1:0] m;
      m = 0;
      foreach (w[i]) if (w[i] > m) m = w[i];
      return m;
   endfunction

   task automatic rand_win(output win_t w);
      for (int i = 0; i < 4; i++) w[i] = DW'($urandom_range(0, (1 << DW) - 1));
   endtask

   // A read issued in one cycle has its data on dout the next.
   always @(posedge clk) rd_vld_q <= rd_issue;

   // Monitor: compare every presented read result against the queue head.
   always @(negedge clk) begin
      if (rd_vld_q) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL rd_unexpected: got 0x%0h, expected no read data", {bus.dout_1, bus.dout_0});
         end else begin
            mon_exp = exp_q.pop_front();
            check("rd_data", {bus.dout_1, bus.dout_0}, mon_exp);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_read(input int a, input logic [DW-1:0] e0, input logic [DW-1:0] e1);
      bus.addr_rd = a[AW-1:0];
      rd_issue    = 1'b1;
      exp_q.push_back({e1, e0});
      @(posedge clk);
      #1;
      rd_issue = 1'b0;
   endtask

   task automatic pulse_tx_done();
      bus.tx_done = 1'b1;
      @(posedge clk);
      #1;
      bus.tx_done = 1'b0;
      mdl_cnt = 0;
   endtask

   // Drives one window starting from an idle cycle. abort_at selects the
   // sample slot (0..3) in which tx_done (or async reset) is applied; -1 none.
   task automatic drive_window(input win_t w0, input win_t w1, input bit hold,
                               input int abort_at, input bit abort_rst);
      bus.rdy_in = 1'b1;
      @(posedge clk);
      #1;
      if (!hold) bus.rdy_in = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.din_0 = w0[i];
         bus.din_1 = w1[i];
         if (i == abort_at) begin
            if (abort_rst) begin
               rst_n = 1'b0;
               #2;
               check("rst_wr_cnt", bus.wr_cnt, 0);
               check("rst_done", bus.done, 0);
               check("rst_dout", {bus.dout_1, bus.dout_0}, 0);
               #2;
               rst_n = 1'b1;
               @(posedge clk);
               #1;
            end else begin
               bus.tx_done = 1'b1;
               @(posedge clk);
               #1;
               bus.tx_done = 1'b0;
            end
            mdl_cnt = 0;
            bus.rdy_in = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
      end
      mdl_0[mdl_cnt] = max_of(w0);
      mdl_1[mdl_cnt] = max_of(w1);
      mdl_cnt++;
   endtask

   win_t          wa, wb;
   logic [DW-1:0] old0, old1;

   initial begin
      bus.tx_done = 1'b0;
      bus.rdy_in  = 1'b0;
      bus.din_0   = '0;
      bus.din_1   = '0;
      bus.addr_rd = '0;

      // Reset values.
      repeat (3) @(posedge clk);
      #1;
      check("reset_wr_cnt", bus.wr_cnt, 0);
      check("reset_done", bus.done, 0);
      check("reset_dout", {bus.dout_1, bus.dout_0}, 0);
      rst_n = 1'b1;
      idle(2);

      // Single window, read back at the earliest legal cycle.
      drive_window('{18'd5, 18'd9, 18'd3, 18'd7}, '{18'd0, 18'd0, 18'd0, 18'd0}, 0, -1, 0);
      check("single_wr_cnt", bus.wr_cnt, 1);
      check("single_done", bus.done, 0);
      do_read(0, 18'd9, 18'd0);

      // Maximum in the last slot, in the first slot, and all-equal ties.
      drive_window('{18'd1, 18'd2, 18'd3, 18'h3FFFF}, '{18'h3FFFF, 18'd0, 18'd0, 18'd0}, 0, -1, 0);
      drive_window('{18'h20000, 18'd1, 18'd1, 18'd1}, '{18'd7, 18'd7, 18'd7, 18'd7}, 0, -1, 0);
      check("edge_wr_cnt", bus.wr_cnt, 3);
      do_read(1, 18'h3FFFF, 18'h3FFFF);
      do_read(2, 18'h20000, 18'd7);

      // A few random windows with idle gaps, read back in random order.
      for (int k = 0; k < 5; k++) begin
         rand_win(wa);
         rand_win(wb);
         drive_window(wa, wb, 0, -1, 0);
         idle($urandom_range(0, 3));
      end
      check("rand_wr_cnt", bus.wr_cnt, 8);
      for (int k = 0; k < 12; k++) begin
         int a;
         a = $urandom_range(0, mdl_cnt - 1);
         do_read(a, mdl_0[a], mdl_1[a]);
      end

      // tx_done in C2: window discarded, RAM retained.
      pulse_tx_done();
      check("txd_clear", bus.wr_cnt, 0);
      rand_win(wa);
      rand_win(wb);
      drive_window(wa, wb, 0, 2, 0);
      check("txd_c2_wr_cnt", bus.wr_cnt, 0);
      do_read(0, mdl_0[0], mdl_1[0]);
      rand_win(wa);
      rand_win(wb);
      drive_window(wa, wb, 0, -1, 0);
      check("after_txd_wr_cnt", bus.wr_cnt, 1);
      do_read(0, mdl_0[0], mdl_1[0]);
      // tx_done in C3 would otherwise write entry 1.
      rand_win(wa);
      rand_win(wb);
      drive_window(wa, wb, 0, 3, 0);
      check("txd_c3_wr_cnt", bus.wr_cnt, 0);
      check("txd_c3_done", bus.done, 0);
      do_read(1, mdl_0[1], mdl_1[1]);

      // Read of entry 0 in the very cycle it is rewritten: old, then new.
      old0 = mdl_0[0];
      old1 = mdl_1[0];
      for (int i = 0; i < 4; i++) begin
         wa[i] = ~old0;
         wb[i] = ~old1;
      end
      fork
         drive_window(wa, wb, 0, -1, 0);
         begin
            repeat (4) @(posedge clk);
            #1;
            do_read(0, old0, old1);
            do_read(0, ~old0, ~old1);
         end
      join
      check("rw_wr_cnt", bus.wr_cnt, 1);

      // Full frame, rdy_in held high: one write every 5 cycles.
      pulse_tx_done();
      for (int k = 0; k < NO; k++) begin
         rand_win(wa);
         rand_win(wb);
         if (k == 7) wa = '{18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 18'h3FFFF};
         if (k == 8) wb = '{18'd0, 18'd0, 18'd0, 18'd0};
         drive_window(wa, wb, 1, -1, 0);
         check("frame_wr_cnt", bus.wr_cnt, k + 1);
         check("frame_done_low", bus.done, 0);
      end
      idle(1);
      check("frame_done", bus.done, 1);
      idle(10);
      check("frame_hold_wr_cnt", bus.wr_cnt, NO);
      bus.rdy_in = 1'b0;
      for (int k = 0; k < 4; k++) begin
         bus.rdy_in = 1'b1;
         idle(1);
         bus.rdy_in = 1'b0;
         idle(6);
      end
      check("frame_pulse_wr_cnt", bus.wr_cnt, NO);
      check("frame_pulse_done", bus.done, 1);
      for (int a = 0; a < NO; a++) do_read(a, mdl_0[a], mdl_1[a]);
      idle(2);

      // Asynchronous reset while the frame is complete.
      rst_n = 1'b0;
      #2;
      check("arst_done", bus.done, 0);
      check("arst_wr_cnt", bus.wr_cnt, 0);
      check("arst_dout", {bus.dout_1, bus.dout_0}, 0);
      mdl_cnt = 0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(2);

      // Asynchronous reset in C1 after two entries.
      for (int k = 0; k < 2; k++) begin
         rand_win(wa);
         rand_win(wb);
         drive_window(wa, wb, 0, -1, 0);
      end
      check("pre_rst_wr_cnt", bus.wr_cnt, 2);
      do_read(1, mdl_0[1], mdl_1[1]);
      idle(1);
      rand_win(wa);
      rand_win(wb);
      drive_window(wa, wb, 0, 1, 1);
      for (int k = 0; k < 6; k++) begin
         bus.din_0 = DW'($urandom);
         bus.din_1 = DW'($urandom);
         idle(1);
      end
      check("post_rst_idle", bus.wr_cnt, 0);
      rand_win(wa);
      rand_win(wb);
      drive_window(wa, wb, 0, -1, 0);
      check("post_rst_wr_cnt", bus.wr_cnt, 1);
      do_read(0, mdl_0[0], mdl_1[0]);

      // Drain the scoreboard.
      idle(4);
      check("drain_queue", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
